// File: rtl/act_char_pkg.sv
// ============================================================================
//  Module : act_char_pkg
//  Brief  : Shared types and metric-width helpers for the activation-circuit
//           error characterizer.
//  Config : ACT_CHAR_SQ_ERR_EN (optional squared-error accumulator)
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package act_char_pkg;

   // Sweep controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Error count must reach 2^IN_W, so one extra bit
   function automatic int cnt_w(input int in_w);
      return in_w + 1;
   endfunction

   // Sum of up to 2^IN_W values of at most 2^OUT_W-1
   function automatic int sum_w(input int in_w, input int out_w);
      return in_w + out_w;
   endfunction

   // Sum of up to 2^IN_W squares of at most (2^OUT_W-1)^2
   function automatic int sq_w(input int in_w, input int out_w);
      return in_w + 2 * out_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/act_err_accum.sv
// ============================================================================
//  Module : act_err_accum
//  Brief  : Per-sample update of the error metric registers (count, sum |e|,
//           max |e| with worst-case input, optional sum e^2).
//  Config : ACT_CHAR_SQ_ERR_EN adds the squared-error accumulator.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module act_err_accum
   import act_char_pkg::*;
#(
   parameter int IN_W  = 4,
   parameter int OUT_W = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              i_clear,
   input  logic                              i_vld,
   input  logic [IN_W-1:0]                   i_tag,
   input  logic [OUT_W-1:0]                  i_dut,
   input  logic [OUT_W-1:0]                  i_ref,
   output logic [cnt_w(IN_W)-1:0]            o_err_cnt,
   output logic [sum_w(IN_W, OUT_W)-1:0]     o_sum_abs_err,
   output logic [OUT_W-1:0]                  o_max_abs_err,
   output logic [IN_W-1:0]                   o_wce_in
`ifdef ACT_CHAR_SQ_ERR_EN
   ,
   output logic [sq_w(IN_W, OUT_W)-1:0]      o_sum_sq_err
`endif
);

   localparam int CNT_W = cnt_w(IN_W);
   localparam int SUM_W = sum_w(IN_W, OUT_W);

   logic [OUT_W-1:0] w_abs;
   logic [CNT_W-1:0] r_err_cnt;
   logic [SUM_W-1:0] r_sum;
   logic [OUT_W-1:0] r_max;
   logic [IN_W-1:0]  r_wce;

   // Unsigned absolute difference of the two result codes
   always_comb begin
      w_abs = (i_dut > i_ref) ? (i_dut - i_ref) : (i_ref - i_dut);
   end

   // Clear on sweep start, otherwise fold in one valid sample per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
         r_sum     <= '0;
         r_max     <= '0;
         r_wce     <= '0;
      end else if (i_clear) begin
         r_err_cnt <= '0;
         r_sum     <= '0;
         r_max     <= '0;
         r_wce     <= '0;
      end else if (i_vld) begin
         if (w_abs != '0) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
         end
         r_sum <= r_sum + SUM_W'(w_abs);
         // Strictly greater: ties keep the earlier, lower input code
         if (w_abs > r_max) begin
            r_max <= w_abs;
            r_wce <= i_tag;
         end
      end
   end

   assign o_err_cnt     = r_err_cnt;
   assign o_sum_abs_err = r_sum;
   assign o_max_abs_err = r_max;
   assign o_wce_in      = r_wce;

`ifdef ACT_CHAR_SQ_ERR_EN
   localparam int SQ_W = sq_w(IN_W, OUT_W);

   logic [2*OUT_W-1:0] w_sq;
   logic [SQ_W-1:0]    r_sq;

   // Square of the absolute error, full precision
   always_comb begin
      w_sq = (2*OUT_W)'(w_abs) * (2*OUT_W)'(w_abs);
   end

   // Squared-error accumulator, cleared and timed like the others
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sq <= '0;
      end else if (i_clear) begin
         r_sq <= '0;
      end else if (i_vld) begin
         r_sq <= r_sq + SQ_W'(w_sq);
      end
   end

   assign o_sum_sq_err = r_sq;
`endif

endmodule

`default_nettype wire

// File: rtl/act_err_characterizer.sv
// ============================================================================
//  Module : act_err_characterizer
//  Brief  : Exhaustive sweep of an approximate activation circuit against an
//           exact model; accumulates error count, sum |e|, max |e| and the
//           lowest input reaching max |e|.
//  Config : ACT_CHAR_SQ_ERR_EN adds o_sum_sq_err (sum of e^2).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module act_err_characterizer
   import act_char_pkg::*;
#(
   parameter int IN_W  = 4,
   parameter int OUT_W = 4,
   parameter int LAT   = 0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              i_start,
   output logic [IN_W-1:0]                   o_dut_in,
   input  logic [OUT_W-1:0]                  i_dut_out,
   input  logic [OUT_W-1:0]                  i_ref_out,
   output logic                              o_busy,
   output logic                              o_done,
   output logic [cnt_w(IN_W)-1:0]            o_err_cnt,
   output logic [sum_w(IN_W, OUT_W)-1:0]     o_sum_abs_err,
   output logic [OUT_W-1:0]                  o_max_abs_err,
   output logic [IN_W-1:0]                   o_wce_in
`ifdef ACT_CHAR_SQ_ERR_EN
   ,
   output logic [sq_w(IN_W, OUT_W)-1:0]      o_sum_sq_err
`endif
);

   localparam logic [IN_W-1:0] c_TOP = '1;

   state_t           r_state;
   logic [IN_W-1:0]  r_dut_in;
   logic             r_busy;
   logic             r_done;
   logic             w_start_acc;
   logic             w_smp_vld;
   logic [IN_W-1:0]  w_smp_tag;

   // start only counts when no sweep is in flight
   assign w_start_acc = i_start && ((r_state == IDLE) || (r_state == DONE));

   // Sweep FSM with stimulus counter and registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_dut_in <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (i_start) begin
                  r_state  <= SWEEP;
                  r_dut_in <= '0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
               end
            end
            SWEEP: begin
               if (r_dut_in == c_TOP) begin
                  // Counter parks on the top code until the next start
                  if (LAT == 0) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= DRAIN;
                  end
               end else begin
                  r_dut_in <= r_dut_in + IN_W'(1);
               end
            end
            DRAIN: begin
               if (w_smp_vld && (w_smp_tag == c_TOP)) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   generate
      if (LAT == 0) begin : g_comb
         // Combinational circuits: sample the stimulus of this very cycle
         assign w_smp_vld = (r_state == SWEEP);
         assign w_smp_tag = r_dut_in;
      end else begin : g_pipe
         logic [LAT-1:0]  r_vld;
         logic [IN_W-1:0] r_tag [LAT];

         // Valid+tag delay line matching the circuit latency
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld <= '0;
               for (int i = 0; i < LAT; i++) begin
                  r_tag[i] <= '0;
               end
            end else if (w_start_acc) begin
               r_vld <= '0;
            end else begin
               r_vld[0] <= (r_state == SWEEP);
               r_tag[0] <= r_dut_in;
               for (int i = 1; i < LAT; i++) begin
                  r_vld[i] <= r_vld[i-1];
                  r_tag[i] <= r_tag[i-1];
               end
            end
         end

         assign w_smp_vld = r_vld[LAT-1];
         assign w_smp_tag = r_tag[LAT-1];
      end
   endgenerate

   act_err_accum #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_accum (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_clear       (w_start_acc),
      .i_vld         (w_smp_vld),
      .i_tag         (w_smp_tag),
      .i_dut         (i_dut_out),
      .i_ref         (i_ref_out),
      .o_err_cnt     (o_err_cnt),
      .o_sum_abs_err (o_sum_abs_err),
      .o_max_abs_err (o_max_abs_err),
      .o_wce_in      (o_wce_in)
`ifdef ACT_CHAR_SQ_ERR_EN
      ,
      .o_sum_sq_err  (o_sum_sq_err)
`endif
   );

   assign o_dut_in = r_dut_in;
   assign o_busy   = r_busy;
   assign o_done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_act_err_characterizer.sv
// ============================================================================
//  Module : tb_act_err_characterizer
//  Brief  : Directed bench for act_err_characterizer; a combinational (LAT=0)
//           and a registered (LAT=2) instance run side by side.
//  Config : ACT_CHAR_SQ_ERR_EN also checks o_sum_sq_err.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_act_err_characterizer;

   logic       clk;
   logic       rst_n;
   logic       start;
   int         mode;
   int         vectors;
   int         miscompares;

   logic [3:0] dut_in0, dut_out0, ref_out0;
   logic       busy0, done0;
   logic [4:0] err0;
   logic [7:0] sum0;
   logic [3:0] max0, wce0;

   logic [3:0] dut_in2, dut_out2, ref_out2;
   logic       busy2, done2;
   logic [4:0] err2;
   logic [7:0] sum2;
   logic [3:0] max2, wce2;
   logic [3:0] x1, x2;

`ifdef ACT_CHAR_SQ_ERR_EN
   logic [11:0] sq0, sq2;
`endif

   // Expected metrics per mode: exact, zero-output, single fault, tie
   int e_err [4] = '{0, 15, 1, 2};
   int e_sum [4] = '{0, 120, 3, 4};
   int e_max [4] = '{0, 15, 3, 2};
   int e_wce [4] = '{0, 15, 9, 3};
   int e_sq  [4] = '{0, 1240, 9, 8};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Approximate circuit model for each mode
   function automatic logic [3:0] f_dut(input int m, input logic [3:0] x);
      case (m)
         1:       return 4'd0;
         2:       return (x == 4'd9) ? 4'd12 : x;
         3:       return (x == 4'd3) ? 4'd5 : ((x == 4'd11) ? 4'd9 : x);
         default: return x;
      endcase
   endfunction

   always_comb begin
      dut_out0 = f_dut(mode, dut_in0);
      ref_out0 = dut_in0;
      dut_out2 = f_dut(mode, x2);
      ref_out2 = x2;
   end

   // Two register stages in front of the LAT=2 circuit and model
   always @(posedge clk) begin
      x1 <= dut_in2;
      x2 <= x1;
   end

   act_err_characterizer #(.IN_W(4), .OUT_W(4), .LAT(0)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (start),
      .o_dut_in      (dut_in0),
      .i_dut_out     (dut_out0),
      .i_ref_out     (ref_out0),
      .o_busy        (busy0),
      .o_done        (done0),
      .o_err_cnt     (err0),
      .o_sum_abs_err (sum0),
      .o_max_abs_err (max0),
      .o_wce_in      (wce0)
`ifdef ACT_CHAR_SQ_ERR_EN
      ,
      .o_sum_sq_err  (sq0)
`endif
   );

   act_err_characterizer #(.IN_W(4), .OUT_W(4), .LAT(2)) u_dut_l2 (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (start),
      .o_dut_in      (dut_in2),
      .i_dut_out     (dut_out2),
      .i_ref_out     (ref_out2),
      .o_busy        (busy2),
      .o_done        (done2),
      .o_err_cnt     (err2),
      .o_sum_abs_err (sum2),
      .o_max_abs_err (max2),
      .o_wce_in      (wce2)
`ifdef ACT_CHAR_SQ_ERR_EN
      ,
      .o_sum_sq_err  (sq2)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_in0"},   32'(dut_in0), 0);
      chk({tag, "_busy0"}, 32'(busy0), 0);
      chk({tag, "_done0"}, 32'(done0), 0);
      chk({tag, "_err0"},  32'(err0), 0);
      chk({tag, "_sum0"},  32'(sum0), 0);
      chk({tag, "_max0"},  32'(max0), 0);
      chk({tag, "_wce0"},  32'(wce0), 0);
      chk({tag, "_in2"},   32'(dut_in2), 0);
      chk({tag, "_busy2"}, 32'(busy2), 0);
      chk({tag, "_err2"},  32'(err2), 0);
      chk({tag, "_sum2"},  32'(sum2), 0);
`ifdef ACT_CHAR_SQ_ERR_EN
      chk({tag, "_sq0"},   32'(sq0), 0);
      chk({tag, "_sq2"},   32'(sq2), 0);
`endif
   endtask

   // One full sweep in mode m; poke re-asserts start while busy
   task automatic run_sweep(input int m, input bit poke);
      int n, n0, n2;
      mode = m;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("start_busy0", 32'(busy0), 1);
      chk("start_done0", 32'(done0), 0);
      chk("start_in0",   32'(dut_in0), 0);
      chk("start_err0",  32'(err0), 0);
      n  = 0;
      n0 = 0;
      n2 = 0;
      while (((n0 == 0) || (n2 == 0)) && (n < 100)) begin
         @(posedge clk);
         #1;
         n++;
         if (poke && (n == 5)) start = 1'b1;
         if (poke && (n == 6)) start = 1'b0;
         if (done0 && (n0 == 0)) n0 = n;
         if (done2 && (n2 == 0)) n2 = n;
      end
      chk("lat0_cycles", 32'(n0), 16);
      chk("lat2_cycles", 32'(n2), 18);
      chk("err0", 32'(err0), 32'(e_err[m]));
      chk("sum0", 32'(sum0), 32'(e_sum[m]));
      chk("max0", 32'(max0), 32'(e_max[m]));
      chk("wce0", 32'(wce0), 32'(e_wce[m]));
      chk("err2", 32'(err2), 32'(e_err[m]));
      chk("sum2", 32'(sum2), 32'(e_sum[m]));
      chk("max2", 32'(max2), 32'(e_max[m]));
      chk("wce2", 32'(wce2), 32'(e_wce[m]));
`ifdef ACT_CHAR_SQ_ERR_EN
      chk("sq0", 32'(sq0), 32'(e_sq[m]));
      chk("sq2", 32'(sq2), 32'(e_sq[m]));
`endif
      // Results must hold steady in DONE
      repeat (3) @(posedge clk);
      #1;
      chk("hold_done0", 32'(done0), 1);
      chk("hold_busy0", 32'(busy0), 0);
      chk("hold_in0",   32'(dut_in0), 15);
      chk("hold_in2",   32'(dut_in2), 15);
      chk("hold_sum0",  32'(sum0), 32'(e_sum[m]));
      chk("hold_wce2",  32'(wce2), 32'(e_wce[m]));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      mode        = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_sweep(0, 1'b0);
      run_sweep(1, 1'b1);
      run_sweep(2, 1'b0);
      run_sweep(3, 1'b0);
      run_sweep(1, 1'b0);

      // Asynchronous reset part-way through a sweep
      mode = 1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_rst_err0", 32'(err0), 4);
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
